// File: rtl/data_memory_sized_if.sv
// rtl/data_memory_sized_if.sv - request/response bundle for data_memory_sized
interface data_memory_sized_if;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        clear_fault;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misaligned;
  logic        out_of_range;
  logic        fault_sticky;
  logic [31:0] fault_addr;

  modport master (
    output mem_write, mem_read, size, unsigned_ld, addr, wdata, clear_fault,
    input  rdata, rvalid, misaligned, out_of_range, fault_sticky, fault_addr
  );

  modport slave (
    input  mem_write, mem_read, size, unsigned_ld, addr, wdata, clear_fault,
    output rdata, rvalid, misaligned, out_of_range, fault_sticky, fault_addr
  );
endinterface

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - byte/half/word data memory, registered read, fault capture
// Optional DMEM_ACCESS_COUNTERS_EN adds rd_count/wr_count outputs.
module data_memory_sized #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  data_memory_sized_if.slave bus
`ifdef DMEM_ACCESS_COUNTERS_EN
  ,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
`endif
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [31:0]      word_rd;
  logic [31:0]      load_val;
  logic [31:0]      wd_rep;
  logic [3:0]       be;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             misal, oor, req, legal, fault;

  assign idx     = bus.addr[IDX_W+1:2];
  assign word_rd = mem[idx];
  assign oor     = |bus.addr[31:IDX_W+2];
  assign req     = bus.mem_read | bus.mem_write;
  assign legal   = ~misal & ~oor;
  assign fault   = req & ~legal;

  always_comb begin
    misal = 1'b0;
    case (bus.size)
      SZ_BYTE: misal = 1'b0;
      SZ_HALF: misal = bus.addr[0];
      SZ_WORD: misal = |bus.addr[1:0];
      default: misal = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = word_rd[7:0];
    case (bus.addr[1:0])
      2'd0: byte_sel = word_rd[7:0];
      2'd1: byte_sel = word_rd[15:8];
      2'd2: byte_sel = word_rd[23:16];
      default: byte_sel = word_rd[31:24];
    endcase
    half_sel = bus.addr[1] ? word_rd[31:16] : word_rd[15:0];
    case (bus.size)
      SZ_BYTE: load_val = {{24{~bus.unsigned_ld & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_val = {{16{~bus.unsigned_ld & half_sel[15]}}, half_sel};
      default: load_val = word_rd;
    endcase
  end

  // Narrow stores replicate the data across lanes; the byte enables pick the lane(s).
  always_comb begin
    be     = 4'b1111;
    wd_rep = bus.wdata;
    case (bus.size)
      SZ_BYTE: begin
        be     = 4'b0001 << bus.addr[1:0];
        wd_rep = {4{bus.wdata[7:0]}};
      end
      SZ_HALF: begin
        be     = bus.addr[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{bus.wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wd_rep = bus.wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && bus.mem_write && legal) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wd_rep[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata        <= 32'd0;
      bus.rvalid       <= 1'b0;
      bus.misaligned   <= 1'b0;
      bus.out_of_range <= 1'b0;
      bus.fault_sticky <= 1'b0;
      bus.fault_addr   <= 32'd0;
    end else begin
      bus.rvalid       <= bus.mem_read;
      bus.misaligned   <= req & misal;
      bus.out_of_range <= req & oor;
      if (bus.mem_read) bus.rdata <= legal ? load_val : 32'd0;
      // A fault arriving with clear_fault re-arms the capture with the new address.
      if (fault && (!bus.fault_sticky || bus.clear_fault)) begin
        bus.fault_sticky <= 1'b1;
        bus.fault_addr   <= bus.addr;
      end else if (bus.clear_fault) begin
        bus.fault_sticky <= 1'b0;
        bus.fault_addr   <= 32'd0;
      end
    end
  end

`ifdef DMEM_ACCESS_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= 32'd0;
      wr_count <= 32'd0;
    end else begin
      if (bus.mem_read && legal)  rd_count <= rd_count + 32'd1;
      if (bus.mem_write && legal) wr_count <= wr_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - scoreboard bench for data_memory_sized against a byte-array model
module tb_data_memory_sized;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  data_memory_sized_if bus();

`ifdef DMEM_ACCESS_COUNTERS_EN
  logic [31:0] rd_count, wr_count;
  data_memory_sized #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rd_count(rd_count), .wr_count(wr_count));
`else
  data_memory_sized #(.DEPTH_WORDS(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        rvalid, mis, oor, st;
    logic [31:0] fa;
    logic [31:0] rc, wc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mm [DEPTH*4];
  logic [31:0] m_rdata = 0, m_fa = 0, m_rc = 0, m_wc = 0;
  logic        m_st = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(int unsigned a, int sz, bit uns);
    int     n = 1 << sz;
    longint v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(mm[a + i]) << (8 * i));
    if (!uns && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic step(bit r, bit rd, bit wr, logic [1:0] sz, bit uns,
                      logic [31:0] a, logic [31:0] wd, bit clr);
    exp_t   e;
    bit     mis, oor, legal;
    longint unsigned ua;
    @(posedge clk);
    #1;
    rst = r;
    bus.mem_read = rd; bus.mem_write = wr; bus.size = sz; bus.unsigned_ld = uns;
    bus.addr = a; bus.wdata = wd; bus.clear_fault = clr;
    ua  = {32'd0, a};
    mis = (sz == 2'b11) || ((ua % (64'd1 << sz)) != 0);
    oor = ua >= 64'(DEPTH) * 4;
    legal = !mis && !oor;
    e.cyc = cyc + 1;
    if (r) begin
      m_rdata = 0; m_st = 0; m_fa = 0; m_rc = 0; m_wc = 0;
      e.rvalid = 0; e.mis = 0; e.oor = 0;
    end else begin
      e.rvalid = rd;
      e.mis = (rd || wr) && mis;
      e.oor = (rd || wr) && oor;
      if (rd) m_rdata = legal ? model_load(a, int'(sz), uns) : 32'd0;
      if (wr && legal) begin
        for (int i = 0; i < (1 << sz); i++) mm[a + i] = wd[8*i +: 8];
      end
      if (rd && legal) m_rc = m_rc + 1;
      if (wr && legal) m_wc = m_wc + 1;
      if ((rd || wr) && !legal && (!m_st || clr)) begin
        m_st = 1; m_fa = a;
      end else if (clr) begin
        m_st = 0; m_fa = 0;
      end
    end
    e.rdata = m_rdata; e.st = m_st; e.fa = m_fa; e.rc = m_rc; e.wc = m_wc;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      chk("rvalid", 32'(bus.rvalid), 32'(e.rvalid));
      chk("rdata", bus.rdata, e.rdata);
      chk("misaligned", 32'(bus.misaligned), 32'(e.mis));
      chk("out_of_range", 32'(bus.out_of_range), 32'(e.oor));
      chk("fault_sticky", 32'(bus.fault_sticky), 32'(e.st));
      chk("fault_addr", bus.fault_addr, e.fa);
`ifdef DMEM_ACCESS_COUNTERS_EN
      chk("rd_count", rd_count, e.rc);
      chk("wr_count", wr_count, e.wc);
`endif
    end
  end

  initial begin
    bus.mem_read = 0; bus.mem_write = 0; bus.size = 0; bus.unsigned_ld = 0;
    bus.addr = 0; bus.wdata = 0; bus.clear_fault = 0;
    for (int i = 0; i < DEPTH * 4; i++) mm[i] = 8'h00;
    repeat (3) step(1, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    // Give the region used below known contents.
    for (int w = 0; w < 32; w++) step(0, 0, 1, 2'b10, 0, 32'(w * 4), $urandom, 0);
    for (int w = 0; w < 32; w++) step(0, 1, 0, 2'b10, 0, 32'(w * 4), 32'h0, 0);

    step(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
    step(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    step(0, 0, 1, 2'b10, 0, 32'h20, 32'h0, 0);
    step(0, 0, 1, 2'b00, 0, 32'h21, 32'h80, 0);
    step(0, 1, 0, 2'b00, 0, 32'h21, 32'h0, 0);
    step(0, 1, 0, 2'b00, 1, 32'h21, 32'h0, 0);
    step(0, 1, 0, 2'b10, 0, 32'h20, 32'h0, 0);
    step(0, 0, 1, 2'b01, 0, 32'h32, 32'h1234, 0);
    step(0, 1, 0, 2'b01, 0, 32'h32, 32'h0, 0);
    step(0, 1, 0, 2'b01, 0, 32'h31, 32'h0, 0);
    step(0, 1, 0, 2'b10, 0, 32'h30, 32'h0, 0);
    step(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 1);
    step(0, 0, 1, 2'b10, 0, 32'h1000, 32'hCAFEF00D, 0);
    step(0, 1, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    step(0, 0, 1, 2'b10, 0, 32'h1003, 32'h12345678, 0);
    step(0, 0, 1, 2'b10, 0, 32'h2, 32'h0, 1);
    step(0, 0, 1, 2'b10, 0, 32'h40, 32'h11, 0);
    step(0, 1, 1, 2'b10, 0, 32'h40, 32'h55, 0);
    step(0, 1, 0, 2'b10, 0, 32'h40, 32'h0, 0);
    step(1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0);
    step(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    step(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, 0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           2'($urandom_range(0, 3)), $urandom_range(0, 1), a, $urandom,
           ($urandom_range(0, 7) == 0));
    end

    repeat (3) step(0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
Parametrised data memory for the monocycle/multicycle MIPS datapath. Generalises the word-only data memory with byte/halfword/word loads and stores, sign/zero extension, a registered one-cycle read and alignment/range fault detection. Sits between the ALU address output and the write-back mux; the controller drives size and sign from the opcode (lb/lbu/lh/lhu/lw/sb/sh/sw).

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, 16..65536
IDX_W, $clog2(DEPTH_WORDS), word-index width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
mem_write  in  1  store request this cycle
mem_read  in  1  load request this cycle
size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
unsigned_ld  in  1  1 = zero-extend load, 0 = sign-extend
addr  in  32  byte address
wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
clear_fault  in  1  clears sticky fault state
rdata  out  32  extended load result, registered
rvalid  out  1  one-cycle pulse: rdata valid
misaligned  out  1  registered pulse: previous-cycle request misaligned or size=11
out_of_range  out  1  registered pulse: previous-cycle request beyond DEPTH_WORDS
fault_sticky  out  1  set by first fault, held until clear_fault/rst
fault_addr  out  32  addr of first fault since last clear

Behaviour:
- Storage: DEPTH_WORDS x 32 array, little-endian byte lanes; lane k = bits [8k+7:8k]; word index = addr[IDX_W+1:2].
- Legal access: size!=11; half needs addr[0]=0; word needs addr[1:0]=00; out_of_range when addr[31:IDX_W+2] != 0.
- Store (legal, rst=0): on posedge, byte writes wdata[7:0] to lane addr[1:0]; half writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}; word writes all lanes. Other lanes unchanged.
- Illegal store: array unchanged; fault reported.
- Load: latency 1. Request in cycle N -> rvalid=1 and rdata in cycle N+1. rvalid pulses one cycle per request; back-to-back requests give back-to-back rvalid.
- Load extraction: select lane/half by addr[1:0]; extend to 32 bits by bit 7/15 unless unsigned_ld=1; word passes through; unsigned_ld ignored for word.
- Illegal load: rvalid still pulses in N+1 with rdata=0.
- No read request: rdata holds last value, rvalid=0.
- mem_read and mem_write same cycle, same word: read-first; rdata returns pre-write contents; write still occurs.
- Faults: misaligned/out_of_range asserted in N+1 for an illegal request in N (read or write); both may assert together. Requests with both enables low never fault.
- Sticky: first fault while fault_sticky=0 sets it and captures addr into fault_addr; later faults do not overwrite fault_addr. clear_fault clears both; clear_fault and new fault in same cycle -> new fault wins (set, capture new addr).
- Reset: rdata=0, rvalid=0, misaligned=0, out_of_range=0, fault_sticky=0, fault_addr=0. Array contents not cleared. Requests presented while rst=1 are dropped: no write, no rvalid, no fault in following cycle.

Optional Feature:
DMEM_ACCESS_COUNTERS_EN: when defined, adds outputs rd_count[31:0] and wr_count[31:0]; each increments by 1 per legal accepted load/store (read-first same-cycle pair increments both); wrap at 2^32 to 0; reset to 0 on rst; not affected by clear_fault. When undefined, ports and logic absent; behaviour otherwise identical.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 -> rvalid in next cycle, rdata=0xDEADBEEF, no fault.
- sb 0x80 @0x21 over word 0x00000000, lb @0x21 -> 0xFFFFFF80; lbu @0x21 -> 0x00000080; lw @0x20 -> 0x00008000.
- sh 0x1234 @0x32 then lh @0x32 -> 0x00001234; lh @0x31 -> misaligned=1, rdata=0, fault_sticky=1, fault_addr=0x31; word @0x30 unchanged.
- DEPTH_WORDS=1024: sw @0x1000 -> out_of_range=1, memory unchanged; following sw @0x1003 -> both flags, fault_addr stays 0x1000; clear_fault with simultaneous fault @0x2 word -> fault_addr=0x2.
- Same-cycle lw+sw 0x55 @0x40 (old 0x11) -> rdata=0x11, next lw -> 0x55.
- Assert rst during lw request -> no rvalid next cycle, all outputs 0; memory data written before reset still readable after.
